// File: rtl/fp_mult.sv
// Two-stage signed integer x fixed-point multiplier with saturation.
// Define FP_MULT_ROUNDING_EN for round-half-up; default truncates (floor).
module fp_mult #(
    parameter int N = 8,
    parameter int F = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    output logic [N-1:0] result,
    output logic         overflow
);

    localparam int W = 2*N + 1;
    typedef logic signed [W-1:0] wide_t;

    localparam wide_t QMAX = (wide_t'(1) <<< (N-1)) - wide_t'(1);
    localparam wide_t QMIN = -(wide_t'(1) <<< (N-1));
`ifdef FP_MULT_ROUNDING_EN
    localparam wide_t RND = wide_t'(1) <<< (F-1);
`else
    localparam wide_t RND = '0;
`endif

    logic                  v1_q;
    logic signed [2*N-1:0] p_q;
    logic signed [2*N-1:0] p_d;
    logic                  v2_q;
    logic [N-1:0]          res_q;
    logic [N-1:0]          res_d;
    logic                  ovf_q;
    logic                  ovf_d;
    wide_t                 sum;
    wide_t                 q;

    // Operands are sign-extended so the truncated 2N-bit product is exact.
    assign p_d = $signed({{N{a[N-1]}}, a}) * $signed({{N{b[N-1]}}, b});

    // One extra bit of headroom keeps the rounding add from wrapping.
    assign sum = wide_t'(p_q) + RND;
    assign q   = sum >>> F;

    always_comb begin
        res_d = q[N-1:0];
        ovf_d = 1'b0;
        if (q > QMAX) begin
            res_d = QMAX[N-1:0];
            ovf_d = 1'b1;
        end else if (q < QMIN) begin
            res_d = QMIN[N-1:0];
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            p_q  <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                p_q <= p_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q  <= 1'b0;
            res_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                res_q <= res_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign out_valid = v2_q;
    assign result    = res_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_fp_mult.sv
// Randomized bench for fp_mult against a real-arithmetic reference model.
// Build with FP_MULT_ROUNDING_EN defined or not; expectations follow the macro.
module tb_fp_mult;

    localparam int N = 8;
    localparam int F = 7;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic [N-1:0] result;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int           due;
        logic [N-1:0] res;
        logic         ovf;
    } exp_t;

    exp_t sb[$];

    fp_mult #(.N(N), .F(F)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, obs, exp, $time);
        end
    endtask

    // Reference: a * b / 2^F in real arithmetic, rounded/floored, saturated.
    function automatic exp_t model(input logic [N-1:0] av,
                                   input logic [N-1:0] bv);
        exp_t e;
        real  x;
        int   qi;
        int   hi;
        int   lo;
        x = $itor($signed(av)) * $itor($signed(bv)) / (2.0 ** F);
`ifdef FP_MULT_ROUNDING_EN
        x = $floor(x + 0.5);
`else
        x = $floor(x);
`endif
        qi  = $rtoi(x);
        hi  = (1 << (N-1)) - 1;
        lo  = -(1 << (N-1));
        e.due = 0;
        e.ovf = 1'b0;
        if (qi > hi) begin
            qi = hi;
            e.ovf = 1'b1;
        end else if (qi < lo) begin
            qi = lo;
            e.ovf = 1'b1;
        end
        e.res = qi[N-1:0];
        return e;
    endfunction

    // Scoreboard: each accepted pair is due two edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (in_valid) begin
                exp_t e;
                e = model(a, b);
                e.due = cyc + 2;
                sb.push_back(e);
            end
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic due_now;
            due_now = (sb.size() > 0) && (sb[0].due == cyc);
            check("out_valid", {31'b0, out_valid}, {31'b0, due_now});
            if (due_now && out_valid) begin
                check("result", {24'b0, result}, {24'b0, sb[0].res});
                check("overflow", {31'b0, overflow}, {31'b0, sb[0].ovf});
                void'(sb.pop_front());
            end
        end
    end

    task automatic send_one(input logic [N-1:0] av, input logic [N-1:0] bv);
        @(negedge clk);
        in_valid = 1'b1;
        a = av;
        b = bv;
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom();
        b = $urandom();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        #1;
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", {24'b0, result}, 32'd0);
        check("rst_ovf", {31'b0, overflow}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        send_one(8'h40, 8'h40);
        check("half_res", {24'b0, result}, 32'h20);
        check("half_ovf", {31'b0, overflow}, 32'd0);

        send_one(8'h03, 8'h40);
`ifdef FP_MULT_ROUNDING_EN
        check("pos_round", {24'b0, result}, 32'h02);
`else
        check("pos_trunc", {24'b0, result}, 32'h01);
`endif
        send_one(8'hFD, 8'h40);
`ifdef FP_MULT_ROUNDING_EN
        check("neg_round", {24'b0, result}, 32'hFF);
`else
        check("neg_trunc", {24'b0, result}, 32'hFE);
`endif
        send_one(8'h80, 8'h80);
        check("sat_res", {24'b0, result}, 32'h7F);
        check("sat_ovf", {31'b0, overflow}, 32'd1);

        send_one(8'h80, 8'h7F);
        check("m127_res", {24'b0, result}, 32'h81);
        check("m127_ovf", {31'b0, overflow}, 32'd0);

        idle(3);
        check("hold_res", {24'b0, result}, 32'h81);

        // Back-to-back stream with in_valid held high.
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            a = $urandom();
            b = $urandom();
            @(negedge clk);
        end
        in_valid = 1'b0;
        idle(4);
        check("stream_drain", sb.size(), 32'd0);

        // Sparse traffic with random gaps, including corner operands.
        for (int i = 0; i < 150; i++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 7))
                0: a = 8'h80;
                1: a = 8'h7F;
                default: a = $urandom();
            endcase
            case ($urandom_range(0, 7))
                0: b = 8'h80;
                1: b = 8'h7F;
                default: b = $urandom();
            endcase
            @(negedge clk);
        end
        in_valid = 1'b0;
        idle(4);
        check("sparse_drain", sb.size(), 32'd0);

        // Reset with a pair in flight: it must vanish.
        send_one(8'h80, 8'h80);
        @(negedge clk);
        in_valid = 1'b1;
        a = 8'h55;
        b = 8'h33;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_result", {24'b0, result}, 32'd0);
        check("midrst_ovf", {31'b0, overflow}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(4);

        send_one(8'h40, 8'h40);
        check("post_rst_res", {24'b0, result}, 32'h20);
        idle(3);
        check("final_drain", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_mult.md
FP_MULT -- requirements
Module: fp_mult

Interface
REQ-001 Parameter N, default 8, meaning total word width of a, b and result in bits (N >= 2).
REQ-002 Parameter F, default 7, meaning number of fractional bits of operand b (0 < F < N).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  high when a and b carry an operand pair to be accepted this cycle.
REQ-007 a  input  N  signed two's-complement integer operand.
REQ-008 b  input  N  signed two's-complement fixed-point operand, F fractional bits (value = b / 2^F).
REQ-009 out_valid  output  1  high for exactly one cycle per accepted operand pair, aligned with result.
REQ-010 result  output  N  signed integer result, a * (b / 2^F), rounded or truncated per REQ-028, saturated.
REQ-011 overflow  output  1  high with out_valid when result was saturated.

Function
REQ-012 Stage 1 SHALL register the full signed 2N-bit product P = a * b when in_valid = 1; a and b are not sampled when in_valid = 0.
REQ-013 Stage 2 SHALL register result, overflow and out_valid computed from the stage-1 product.
REQ-014 Latency SHALL be exactly 2 clk cycles from the in_valid edge to the out_valid edge.
REQ-015 Throughput SHALL be one operand pair per cycle; back-to-back in_valid pulses produce back-to-back out_valid pulses in order.
REQ-016 There is no back-pressure; out_valid SHALL be a 2-cycle delayed copy of in_valid.
REQ-017 Scaling: Q = (P + R) >>> F (arithmetic shift), where R is the rounding term of REQ-028; the intermediate is 2N+1 bits wide so the addition never wraps.
REQ-018 If Q > 2^(N-1)-1, result SHALL be 2^(N-1)-1 and overflow = 1.
REQ-019 If Q < -2^(N-1), result SHALL be -2^(N-1) and overflow = 1.
REQ-020 Otherwise result SHALL be Q[N-1:0] and overflow = 0.
REQ-021 Only the case a = b = -2^(N-1) can saturate with default parameters (Q = 2^(N-1)).
REQ-022 When out_valid = 0, result and overflow SHALL hold their last valid values.
REQ-023 The datapath SHALL be purely synchronous apart from the reset; there are no combinational paths from inputs to outputs.

Reset
REQ-024 While rst_n = 0, out_valid, result, overflow and all pipeline registers, including the internal valid bits, SHALL be 0 immediately, without waiting for a clk edge.
REQ-025 Operand pairs in flight when reset asserts SHALL be discarded, with no out_valid for them after release.
REQ-026 The first in_valid sampled on a rising clk edge after rst_n deasserts SHALL be processed normally.

Configuration
REQ-027 The macro FP_MULT_ROUNDING_EN SHALL select the rounding mode at compile time.
REQ-028 Defined: R = 2^(F-1), i.e. round-half-up toward +infinity, so result error is at most 0.5 LSB; undefined: R = 0, i.e. truncation toward -infinity (floor), so error is under 1 LSB.
REQ-029 Latency, saturation and handshake SHALL be identical in both modes.

Verification
REQ-030 a=0x40, b=0x40 (0.5), in_valid 1 cycle -> 2 cycles later out_valid=1, result=0x20, overflow=0.
REQ-031 a=3, b=0x40 -> result 2 with FP_MULT_ROUNDING_EN, 1 without; a=0xFD (-3), b=0x40 -> result -1 (0xFF) with FP_MULT_ROUNDING_EN, -2 (0xFE) without.
REQ-032 a=0x80, b=0x80 -> result=0x7F, overflow=1; a=0x80, b=0x7F -> result=0x81 (-127), overflow=0.
REQ-033 100 random pairs streamed with in_valid held high -> 100 consecutive out_valid pulses, each |result - a*b/128| <= 0.5 with FP_MULT_ROUNDING_EN, in input order.
REQ-034 rst_n pulsed low between in_valid and its out_valid -> outputs 0 at once, no out_valid for that pair, next pair after release correct with latency 2.
